// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM port-2 arbiter.
//   arb_state_t : IDLE -> ACCESS -> RESP -> IDLE transaction FSM
//   mem_req_t   : latched winning request (sized for the widest build, 32/32)
//   NUM_REQ     : number of requesters sharing the port
package mem_arb_pkg;

   localparam int NUM_REQ    = 2;
   localparam int REQ_IDX_W  = 1;
   localparam int MAX_ADDR_W = 32;
   localparam int MAX_DATA_W = 32;
   localparam int CNT_W      = 4;   // WAIT_CYCLES range 0..15

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [MAX_ADDR_W-1:0] addr;
      logic [MAX_DATA_W-1:0] wdata;
      logic [3:0]            wmask;
      logic                  wen;
   } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester channels plus RAM port-2 signals.
//   slave  : arbiter side (takes requests and rdata, drives ready/resp/mem_*)
//   master : environment side (requesters + RAM)
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]             req_wen;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0][3:0]        req_wmask;
   logic [NUM_REQ-1:0]             resp_valid;
   logic [DATA_W-1:0]              resp_rdata;
   logic                           mem_wen;
   logic [ADDR_W-1:0]              mem_addr;
   logic [DATA_W-1:0]              mem_wdata;
   logic [3:0]                     mem_wmask;
   logic [DATA_W-1:0]              mem_rdata;

   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wmask, mem_rdata,
      output req_ready, resp_valid, resp_rdata,
             mem_wen, mem_addr, mem_wdata, mem_wmask
   );

   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wmask, mem_rdata,
      input  req_ready, resp_valid, resp_rdata,
             mem_wen, mem_addr, mem_wdata, mem_wmask
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick.
//   valid      in  [1:0] request valids
//   last_grant in  index of the requester served last
//   grant      out [1:0] one-hot pick (zero when nothing valid)
//   grant_idx  out index of the pick
//   grant_any  out some requester picked
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0]   valid,
   input  logic [REQ_IDX_W-1:0] last_grant,
   output logic [NUM_REQ-1:0]   grant,
   output logic [REQ_IDX_W-1:0] grant_idx,
   output logic                 grant_any
);

   always_comb begin
      grant = valid;
      // On a tie, the requester that did not win last time goes next.
      if (&valid)
         grant = last_grant ? 2'b01 : 2'b10;
      grant_idx = grant[1];
      grant_any = |valid;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of RAM port 2 between the load/store
// unit (requester 0) and the debug/DMA loader (requester 1).
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         mem_port_arbiter_if.slave:
//                 req_valid/req_ready + payload per requester,
//                 resp_valid (one-cycle pulse) / resp_rdata,
//                 mem_wen/mem_addr/mem_wdata/mem_wmask out, mem_rdata in
// One transaction every WAIT_CYCLES+3 cycles: grant in IDLE, strobe at the
// end of ACCESS, response pulse in RESP.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 0
)(
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   arb_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   mem_req_t               req_q, req_d;
   logic [REQ_IDX_W-1:0]   gnt_q, gnt_d;
   logic [REQ_IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;

   logic [NUM_REQ-1:0]     pick;
   logic [REQ_IDX_W-1:0]   pick_idx;
   logic                   pick_any;
   logic                   strobe;

   rr_arbiter2 u_rr (
      .valid      (bus.req_valid),
      .last_grant (last_grant_q),
      .grant      (pick),
      .grant_idx  (pick_idx),
      .grant_any  (pick_any)
   );

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_q        <= '0;
         gnt_q        <= '0;
         last_grant_q <= 1'b1;   // requester 0 wins the first tie
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         rdata_q      <= rdata_d;
      end
   end

   // ---------------- next-state / datapath ----------------
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      rdata_d      = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               req_d.addr  = MAX_ADDR_W'(bus.req_addr[pick_idx]);
               req_d.wdata = MAX_DATA_W'(bus.req_wdata[pick_idx]);
               req_d.wmask = bus.req_wmask[pick_idx];
               req_d.wen   = bus.req_wen[pick_idx];
               cnt_d       = WAIT_INIT;
               gnt_d       = pick_idx;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // Combinational RAM read: this is the pre-write word on a write.
               rdata_d = bus.mem_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
            last_grant_d = gnt_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   assign strobe = (state_q == ACCESS) && (cnt_q == '0);

   always_comb begin
      // rst_n gate keeps ready low while reset is held with valids pending.
      bus.req_ready  = (state_q == IDLE && rst_n) ? pick : '0;
      bus.mem_wen    = strobe & req_q.wen;
      bus.mem_wmask  = (strobe && req_q.wen) ? req_q.wmask : 4'b0000;
      bus.mem_addr   = req_q.addr[ADDR_W-1:0];
      bus.mem_wdata  = req_q.wdata[DATA_W-1:0];
      bus.resp_rdata = rdata_q;
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_resp
      assign bus.resp_valid[i] = (state_q == RESP) && (gnt_q == REQ_IDX_W'(i));
   end

endmodule
